nibble_demux: RTL and testbench
===============================

# nibble_demux

Sequential 1-to-N demultiplexer with valid/ready handshakes, the distributing counterpart of the ALU's 2:1 nibble select mux. It accepts one WIDTH-bit data word per transfer, tagged with a destination index. It delivers the word to exactly one of NUM_OUT output channels, each buffered by a one-entry holding register. It sits between ALU result slicing and downstream consumers such as writeback lanes, so that one slow consumer never corrupts or duplicates data bound for another.

## Interface
- WIDTH, 4, data width per transfer
- NUM_OUT, 4, number of output channels (2..16)
- SEL_W, $clog2(NUM_OUT), destination index width
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  input word present
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  data word
- in_sel  input  SEL_W  destination channel index
- out_valid  output  NUM_OUT  bit i: channel i holds a word
- out_ready  input  NUM_OUT  bit i: consumer i takes the word this cycle
- out_data  output  NUM_OUT*WIDTH  slice i is the channel i word
- sel_err  output  1  sticky flag: an out-of-range index was accepted

## Operation
- Per-channel state is EMPTY or FULL, held in out_valid[i].
- Transfer in: in_valid && in_ready. Transfer out on channel i: out_valid[i] && out_ready[i].
- in_ready = 1 when in_sel >= NUM_OUT. Otherwise in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - This gives pass-through: a full channel that is draining this cycle accepts a new word in the same cycle.
- Accept to channel s: on the next edge, slice s of out_data is loaded with in_data and out_valid[s] becomes 1.
- Simultaneous drain and accept on the same channel: the channel stays FULL and holds the new word; no bubble.
- Drain with no accept on that channel: out_valid[i] becomes 0. The out_data slice keeps its stale value.
- Channels are independent. A stalled channel i never blocks an accept to channel j≠i.
- Out-of-range in_sel (≥ NUM_OUT): the word is accepted and discarded, and sel_err is set. sel_err clears only on reset.
- While out_valid[i] = 1, out_data slice i is stable; it must not change until the word drains.
- in_ready depends combinationally on in_sel and out_ready only, never on in_valid.
- Reset values: out_valid = 0, out_data = 0, sel_err = 0. in_ready is 1 after reset, since all channels are EMPTY.
- Reset asserted mid-transfer: any word held at that edge is lost, and an accept presented that cycle is ignored.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word per cycle sustained, including back-to-back words to the same channel when its consumer holds out_ready = 1.
- There are no multicycle paths.
- Combinational paths: out_ready → in_ready and in_sel → in_ready. Downstream logic must not feed in_ready back into out_ready.

## Configuration
- DEMUX_STATS_EN defined:
  - Adds output stat_count, NUM_OUT*8 bits wide. Slice i is an 8-bit counter of words drained from channel i.
  - Each counter wraps 255 → 0 and resets to 0.
  - A drain and an accept in the same cycle increment the counter by exactly 1.
- DEMUX_STATS_EN undefined: the port and the counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package holds:
  - the channel state enum {CH_EMPTY, CH_FULL};
  - the localparam default widths;
  - the stat counter width constant (8).
- One sub-module, nibble_demux_slot: the one-entry holding register with its handshake logic, instantiated NUM_OUT times through generate.
- The top level decodes in_sel, muxes in_ready, and owns sel_err.

## Test plan
- Reset, then in_sel=2, in_data=4'hA, out_ready=0 → the next cycle out_valid=4'b0100 and slice 2 = 4'hA. A second word to channel 2 sees in_ready=0.
- Channel 2 held full and stalled; send 4'h5 to channel 0 → accepted at once, out_valid=4'b0101.
- Channel 1 full with out_ready[1]=1; send 4'h3 to channel 1 in the same cycle → in_ready=1, out_valid[1] stays 1, slice 1 = 4'h3.
- NUM_OUT=3, in_sel=3, in_valid=1 → in_ready=1, no out_valid bit changes, and sel_err=1 from the next cycle until reset.
- Load channels 0 and 3, then assert reset for one cycle while in_valid=1 → out_valid=0, sel_err=0, no word accepted.
- DEMUX_STATS_EN: 257 drains on channel 0 → stat_count slice 0 = 1.

Source files
------------

// File: rtl/nibble_demux_pkg.sv
// Shared types and default widths for the nibble demultiplexer.
package nibble_demux_pkg;

    // Per-channel holding register state.
    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_NUM_OUT = 4;
    localparam int unsigned STAT_W      = 8;

endpackage

// File: rtl/nibble_demux_slot.sv
// One-entry holding register with valid/ready handshake for a single output channel.
// Optional drain counter when DEMUX_STATS_EN is defined.
module nibble_demux_slot
    import nibble_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
`ifdef DEMUX_STATS_EN
    output logic [STAT_W-1:0] stat_count,
`endif
    output logic             ready_c,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    ch_state_e state;
    logic      drain;

    // Free slot, or a full slot that empties this cycle, can take a word.
    assign drain     = (state == CH_FULL) && out_ready;
    assign ready_c   = (state == CH_EMPTY) || out_ready;
    assign out_valid = (state == CH_FULL);

    // Load wins over drain so a pass-through keeps the channel full.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CH_EMPTY;
            out_data <= '0;
        end else if (load) begin
            state    <= CH_FULL;
            out_data <= in_data;
        end else if (drain) begin
            state    <= CH_EMPTY;
        end
    end

`ifdef DEMUX_STATS_EN
    // Count words leaving the channel; wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_count <= '0;
        end else if (drain) begin
            stat_count <= stat_count + STAT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/nibble_demux.sv
// 1-to-NUM_OUT demultiplexer with per-channel one-entry buffers.
// Define DEMUX_STATS_EN to add per-channel drain counters on stat_count.
module nibble_demux
    import nibble_demux_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NUM_OUT = DEF_NUM_OUT,
    parameter int unsigned SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
`ifdef DEMUX_STATS_EN
    output logic [NUM_OUT*STAT_W-1:0] stat_count,
`endif
    output logic                     sel_err
);

    localparam int unsigned SEL_SPAN = 1 << SEL_W;

    logic [NUM_OUT-1:0]  slot_ready;
    logic [NUM_OUT-1:0]  load;
    logic [SEL_SPAN-1:0] ready_pad;
    logic                sel_oor;

    // Unused index codes read as ready so out-of-range words are swallowed.
    always_comb begin
        ready_pad                = '1;
        ready_pad[NUM_OUT-1:0]   = slot_ready;
    end

    assign in_ready = ready_pad[in_sel];

    // Out-of-range detection only exists when NUM_OUT leaves spare codes.
    generate
        if (NUM_OUT == SEL_SPAN) begin : g_no_oor
            assign sel_oor = 1'b0;
        end else begin : g_oor
            assign sel_oor = (in_sel >= SEL_W'(NUM_OUT));
        end
    endgenerate

    // One holding slot per output channel.
    generate
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
            assign load[i] = in_valid && slot_ready[i] && (in_sel == SEL_W'(i));

            nibble_demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clock      (clock),
                .reset      (reset),
                .load       (load[i]),
                .in_data    (in_data),
                .out_ready  (out_ready[i]),
`ifdef DEMUX_STATS_EN
                .stat_count (stat_count[i*STAT_W +: STAT_W]),
`endif
                .ready_c    (slot_ready[i]),
                .out_valid  (out_valid[i]),
                .out_data   (out_data[i*WIDTH +: WIDTH])
            );
        end
    endgenerate

    // Sticky flag for accepted out-of-range indices.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (in_valid && sel_oor) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nibble_demux.sv
// Directed bench for nibble_demux: a 4-channel and a 3-channel instance.
module tb_nibble_demux;

    logic        clk = 1'b0;
    logic        reset;

    logic        v4, ir4, se4;
    logic [1:0]  sel4;
    logic [3:0]  data4;
    logic [3:0]  ov4, rdy4;
    logic [15:0] od4;

    logic        v3, ir3, se3;
    logic [1:0]  sel3;
    logic [3:0]  data3;
    logic [2:0]  ov3, rdy3;
    logic [11:0] od3;

`ifdef DEMUX_STATS_EN
    logic [31:0] stat4;
    logic [23:0] stat3;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nibble_demux #(.WIDTH(4), .NUM_OUT(4)) dut4 (
        .clock     (clk),
        .reset     (reset),
        .in_valid  (v4),
        .in_ready  (ir4),
        .in_data   (data4),
        .in_sel    (sel4),
        .out_valid (ov4),
        .out_ready (rdy4),
        .out_data  (od4),
`ifdef DEMUX_STATS_EN
        .stat_count(stat4),
`endif
        .sel_err   (se4)
    );

    nibble_demux #(.WIDTH(4), .NUM_OUT(3)) dut3 (
        .clock     (clk),
        .reset     (reset),
        .in_valid  (v3),
        .in_ready  (ir3),
        .in_data   (data3),
        .in_sel    (sel3),
        .out_valid (ov3),
        .out_ready (rdy3),
        .out_data  (od3),
`ifdef DEMUX_STATS_EN
        .stat_count(stat3),
`endif
        .sel_err   (se3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        v4 = 1'b0; sel4 = 2'd0; data4 = 4'h0; rdy4 = 4'b0000;
        v3 = 1'b0; sel3 = 2'd0; data3 = 4'h0; rdy3 = 3'b000;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_ov4", 32'(ov4), 32'h0);
        check("rst_od4", 32'(od4), 32'h0);
        check("rst_se4", 32'(se4), 32'h0);
        check("rst_ir4", 32'(ir4), 32'h1);
        check("rst_ov3", 32'(ov3), 32'h0);

        // Word A to channel 2 with consumer stalled
        v4 = 1'b1; sel4 = 2'd2; data4 = 4'hA;
        #1 check("ch2_ready", 32'(ir4), 32'h1);
        tick();
        check("ch2_ov", 32'(ov4), 32'b0100);
        check("ch2_data", 32'(od4[11:8]), 32'hA);
        data4 = 4'h7;
        #1 check("ch2_full_block", 32'(ir4), 32'h0);
        tick();
        check("ch2_hold_ov", 32'(ov4), 32'b0100);
        check("ch2_hold_data", 32'(od4[11:8]), 32'hA);

        // Stalled channel 2 does not block channel 0
        sel4 = 2'd0; data4 = 4'h5;
        #1 check("ch0_ready", 32'(ir4), 32'h1);
        tick();
        check("ch0_ov", 32'(ov4), 32'b0101);
        check("ch0_data", 32'(od4[3:0]), 32'h5);

        // Fill channel 1, then pass-through while it drains
        sel4 = 2'd1; data4 = 4'h9;
        tick();
        check("ch1_ov", 32'(ov4), 32'b0111);
        check("ch1_data9", 32'(od4[7:4]), 32'h9);
        data4 = 4'h3;
        #1 check("ch1_full_block", 32'(ir4), 32'h0);
        rdy4 = 4'b0010;
        #1 check("ch1_pass_ready", 32'(ir4), 32'h1);
        tick();
        check("ch1_pass_ov", 32'(ov4), 32'b0111);
        check("ch1_pass_data", 32'(od4[7:4]), 32'h3);
        v4 = 1'b0;
        tick();
        check("ch1_drain_ov", 32'(ov4), 32'b0101);
        check("ch1_stale_data", 32'(od4[7:4]), 32'h3);
        rdy4 = 4'b0000;

        // in_ready ignores in_valid; follows out_ready of the selected channel
        sel4 = 2'd2;
        #1 check("rdy_no_valid_blk", 32'(ir4), 32'h0);
        rdy4 = 4'b0100;
        #1 check("rdy_no_valid_pass", 32'(ir4), 32'h1);
        rdy4 = 4'b0000;

        // Back-to-back words into channel 0 while its consumer drains
        rdy4 = 4'b0001; v4 = 1'b1; sel4 = 2'd0; data4 = 4'h1;
        tick();
        check("b2b_data1", 32'(od4[3:0]), 32'h1);
        data4 = 4'h2;
        tick();
        check("b2b_ov", 32'(ov4), 32'b0101);
        check("b2b_data2", 32'(od4[3:0]), 32'h2);
        v4 = 1'b0;
        tick();
        check("b2b_drain_ov", 32'(ov4), 32'b0100);
        rdy4 = 4'b0000;

        // Out-of-range index on the 3-channel instance
        v3 = 1'b1; sel3 = 2'd3; data3 = 4'hF;
        #1 check("oor_ready", 32'(ir3), 32'h1);
        check("oor_err_pre", 32'(se3), 32'h0);
        tick();
        check("oor_ov", 32'(ov3), 32'h0);
        check("oor_err", 32'(se3), 32'h1);
        v3 = 1'b0;
        tick();
        check("oor_err_sticky", 32'(se3), 32'h1);
        check("oor_no_err4", 32'(se4), 32'h0);

        // Load channels 0 and 3, then reset with an accept presented
        v4 = 1'b1; sel4 = 2'd0; data4 = 4'hC;
        tick();
        sel4 = 2'd3; data4 = 4'hD;
        tick();
        check("pre_rst_ov", 32'(ov4), 32'b1101);
        check("pre_rst_d3", 32'(od4[15:12]), 32'hD);
        reset = 1'b1; sel4 = 2'd1; data4 = 4'hE;
        tick();
        reset = 1'b0; v4 = 1'b0;
        check("mid_rst_ov4", 32'(ov4), 32'h0);
        check("mid_rst_od4", 32'(od4), 32'h0);
        check("mid_rst_se4", 32'(se4), 32'h0);
        check("mid_rst_se3", 32'(se3), 32'h0);
        check("mid_rst_ir4", 32'(ir4), 32'h1);

`ifdef DEMUX_STATS_EN
        // 257 drains on channel 0: counter wraps to 1
        check("stat_rst", 32'(stat4), 32'h0);
        rdy4 = 4'b0001; v4 = 1'b1; sel4 = 2'd0; data4 = 4'h6;
        for (int k = 0; k < 257; k++) tick();
        v4 = 1'b0;
        tick();
        rdy4 = 4'b0000;
        check("stat_ch0_wrap", 32'(stat4[7:0]), 32'h1);
        check("stat_other", 32'(stat4[31:8]), 32'h0);
        check("stat_ch0_empty", 32'(ov4), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
